// File: rtl/acc_feed_fifo.sv
// acc_feed_fifo: FIFO feeding a 32-bit accumulator, with a shadow running sum and sticky check flags.
//
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   in_valid       producer offers in_value
//   in_value       producer data
//   in_ready       FIFO can accept this cycle (count != DEPTH)
//   drain_en       permits one pop this cycle
//   valid, value   registered output pair driving the accumulator
//   accumulator    the accumulator register being fed
//   resync         load the shadow sum from accumulator
//   count          current FIFO occupancy
//   expected_sum   shadow running sum of every emitted value
//   mismatch       sticky: accumulator differed from expected_sum
//   overflow       sticky: expected_sum wrapped
module acc_feed_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_value,
    output logic                       in_ready,
    input  logic                       drain_en,
    output logic                       valid,
    output logic [WIDTH-1:0]           value,
    input  logic [WIDTH-1:0]           accumulator,
    input  logic                       resync,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           expected_sum,
    output logic                       mismatch,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             mismatch_q, mismatch_d;
    logic             overflow_q, overflow_d;
    logic             push, pop;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum_ext;

    assign in_ready = (count_q != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = drain_en && (count_q != '0);

    // The accumulator adds value on the same edge as valid, so the shadow does too.
    assign addend  = valid_q ? value_q : '0;
    assign sum_ext = {1'b0, sum_q} + {1'b0, addend};

    always_comb begin
        head_d     = pop ? head_q + 1'b1 : head_q;
        tail_d     = push ? tail_q + 1'b1 : tail_q;
        count_d    = (push && !pop) ? count_q + 1'b1 :
                     (pop && !push) ? count_q - 1'b1 : count_q;
        valid_d    = pop;
        value_d    = pop ? mem_q[head_q] : value_q;
        sum_d      = resync ? accumulator + addend : sum_ext[WIDTH-1:0];
        overflow_d = overflow_q || (!resync && sum_ext[WIDTH]);
        mismatch_d = mismatch_q || (!resync && (accumulator != sum_q));
    end

    // Storage is not reset: pointers and count alone decide what is readable.
    always_ff @(posedge clock) begin
        if (push) mem_q[tail_q] <= in_value;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            value_q    <= '0;
            sum_q      <= '0;
            mismatch_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            value_q    <= value_d;
            sum_q      <= sum_d;
            mismatch_q <= mismatch_d;
            overflow_q <= overflow_d;
        end
    end

    assign valid        = valid_q;
    assign value        = value_q;
    assign count        = count_q;
    assign expected_sum = sum_q;
    assign mismatch     = mismatch_q;
    assign overflow     = overflow_q;
endmodule

// File: tb/tb_acc_feed_fifo.sv
// tb_acc_feed_fifo: directed checks of acc_feed_fifo against a behavioural accumulator.
module tb_acc_feed_fifo;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_value = '0;
    logic        in_ready;
    logic        drain_en = 1'b0;
    logic        valid;
    logic [31:0] value;
    logic [31:0] accumulator;
    logic        resync = 1'b0;
    logic [3:0]  count;
    logic [31:0] expected_sum;
    logic        mismatch;
    logic        overflow;

    logic [31:0] acc = '0;
    logic        acc_load = 1'b0;
    logic [31:0] acc_ld_val = '0;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_val = '0;
    int          vectors = 0;
    int          errs = 0;

    acc_feed_fifo #(.DEPTH(8), .WIDTH(32)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_value(in_value),
        .in_ready(in_ready), .drain_en(drain_en), .valid(valid), .value(value),
        .accumulator(accumulator), .resync(resync), .count(count),
        .expected_sum(expected_sum), .mismatch(mismatch), .overflow(overflow)
    );

    always #5 clock = ~clock;

    // Environment accumulator: unreset register adding value whenever valid.
    always @(posedge clock) acc <= acc_load ? acc_ld_val : (valid ? acc + value : acc);
    assign accumulator = ovr_en ? ovr_val : acc;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_valid"}, 32'(valid), 0);
        chk({tag, "_value"}, value, 0);
        chk({tag, "_sum"}, expected_sum, 0);
        chk({tag, "_mismatch"}, 32'(mismatch), 0);
        chk({tag, "_overflow"}, 32'(overflow), 0);
        chk({tag, "_ready"}, 32'(in_ready), 1);
    endtask

    initial begin
        step();
        chk_reset("rst0");
        reset = 1'b0;
        resync = 1'b1;
        step();
        resync = 1'b0;
        chk("resync0_sum", expected_sum, 0);

        // 1: push 1,2,3 back to back with drain enabled
        drain_en = 1'b1;
        in_valid = 1'b1;
        in_value = 1;
        step();
        chk("t1_lat_valid", 32'(valid), 0);
        in_value = 2;
        step();
        chk("t1_v1", 32'(valid), 1);
        chk("t1_d1", value, 1);
        in_value = 3;
        step();
        chk("t1_d2", value, 2);
        chk("t1_sum1", expected_sum, 1);
        in_valid = 1'b0;
        step();
        chk("t1_d3", value, 3);
        chk("t1_v3", 32'(valid), 1);
        step();
        chk("t1_vend", 32'(valid), 0);
        chk("t1_hold", value, 3);
        chk("t1_sum", expected_sum, 6);
        chk("t1_acc", accumulator, 6);
        chk("t1_mm", 32'(mismatch), 0);
        chk("t1_cnt", 32'(count), 0);

        // 2: fill without draining, offer one extra entry while full
        drain_en = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t2_ready", 32'(in_ready), 1);
            in_value = 10 + i;
            step();
        end
        chk("t2_full_cnt", 32'(count), 8);
        chk("t2_full_rdy", 32'(in_ready), 0);
        in_value = 99;
        step();
        chk("t2_nopush_cnt", 32'(count), 8);

        // 3: full with push and pop requested: pop only
        drain_en = 1'b1;
        in_value = 18;
        step();
        chk("t3_cnt7", 32'(count), 7);
        chk("t3_rdy", 32'(in_ready), 1);
        chk("t3_d10", value, 10);
        step();
        chk("t3_cnt7b", 32'(count), 7);
        chk("t3_d11", value, 11);
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("t3_order", value, 12 + i);
            chk("t3_valid", 32'(valid), 1);
        end
        step();
        chk("t3_vend", 32'(valid), 0);
        chk("t3_cnt0", 32'(count), 0);
        chk("t3_sum", expected_sum, 132);
        chk("t3_mm", 32'(mismatch), 0);
        chk("t3_ov", 32'(overflow), 0);

        // 4: wrap the shadow sum in step with the accumulator
        acc_load = 1'b1;
        acc_ld_val = 32'hFFFF_FFF0;
        step();
        acc_load = 1'b0;
        resync = 1'b1;
        step();
        resync = 1'b0;
        chk("t4_resync", expected_sum, 32'hFFFF_FFF0);
        in_valid = 1'b1;
        in_value = 32'h20;
        step();
        in_valid = 1'b0;
        step();
        chk("t4_d", value, 32'h20);
        step();
        chk("t4_sum", expected_sum, 32'h10);
        chk("t4_ov", 32'(overflow), 1);
        chk("t4_mm", 32'(mismatch), 0);

        // 5: one cycle of an off-by-one accumulator
        ovr_en = 1'b1;
        ovr_val = 32'h11;
        step();
        chk("t5_mm_set", 32'(mismatch), 1);
        ovr_en = 1'b0;
        step();
        chk("t5_mm_sticky", 32'(mismatch), 1);
        chk("t5_ov_sticky", 32'(overflow), 1);

        // 6: reset mid-stream with count=5 and valid=1
        drain_en = 1'b0;
        in_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_value = i;
            step();
        end
        drain_en = 1'b1;
        in_value = 6;
        step();
        chk("t6_cnt5", 32'(count), 5);
        chk("t6_v1", 32'(valid), 1);
        reset = 1'b1;
        in_value = 7;
        acc_load = 1'b1;
        acc_ld_val = 0;
        step();
        chk_reset("rst1");
        reset = 1'b0;
        acc_load = 1'b0;
        in_valid = 1'b0;
        drain_en = 1'b0;
        resync = 1'b1;
        step();
        resync = 1'b0;
        chk("t6_cnt_after", 32'(count), 0);
        in_valid = 1'b1;
        in_value = 32'h55;
        drain_en = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("t6_new", value, 32'h55);
        step();
        chk("t6_vend", 32'(valid), 0);
        chk("t6_cnt0", 32'(count), 0);
        chk("t6_sum", expected_sum, 32'h55);
        chk("t6_mm", 32'(mismatch), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/acc_feed_fifo.md
Name: acc_feed_fifo

Overview:
- Real-RTL upstream stage for the top-level 32-bit accumulator; drives its valid/value pair.
- Buffers a producer stream (Lua-driven through HSE/dummy-vpi, or RTL) in a small FIFO and drains at most one entry per cycle into the accumulator.
- Keeps a shadow running sum of everything it has emitted and compares it against the accumulator it feeds, raising sticky mismatch and overflow flags for checking.

Parameters:
- DEPTH, 8: FIFO entries; power of two, at least 2.
- WIDTH, 32: data width; must equal the accumulator width.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  producer offers in_value
- in_value  input  WIDTH  producer data
- in_ready  output  1  FIFO can accept this cycle
- drain_en  input  1  permits a pop this cycle
- valid  output  1  registered; to accumulator acc_valid
- value  output  WIDTH  registered; to accumulator acc_value
- accumulator  input  WIDTH  accumulator register being fed
- resync  input  1  load the shadow sum from accumulator
- count  output  $clog2(DEPTH+1)  current FIFO occupancy
- expected_sum  output  WIDTH  shadow running sum
- mismatch  output  1  sticky: accumulator != expected_sum seen
- overflow  output  1  sticky: expected_sum wrapped

Behaviour:
- Reset (synchronous, reset=1 at a rising edge):
  - count=0, valid=0, value=0, expected_sum=0, mismatch=0, overflow=0.
  - FIFO pointers return to 0 and stored contents are discarded.
  - Reset overrides push, pop and resync in the same cycle; it may be asserted mid-stream.
- in_ready = (count != DEPTH), combinational from the count register.
- Push = in_valid && in_ready. in_value is written at the tail and the tail pointer wraps modulo DEPTH.
- Pop = drain_en && (count != 0). On a pop edge: valid<=1 and value<=head entry, and the head pointer wraps modulo DEPTH. With no pop: valid<=0 and value holds its last value.
- Count update:
  - push && pop: unchanged.
  - push only: +1.
  - pop only: -1.
- Full FIFO: in_ready=0, so there is no push even if a pop happens that cycle (no bypass). Empty FIFO: no pop, and there is no in→out bypass.
- Latency: in_valid accepted in cycle c, FIFO empty, drain_en=1 → valid=1 with that value in cycle c+2. Sustained throughput is 1 entry per cycle.
- Ordering is strict FIFO.
- Shadow sum:
  - At every edge where valid=1: expected_sum <= expected_sum + value, truncated to WIDTH.
  - If that carry-out is set: overflow<=1, sticky.
  - This tracks the accumulator update, which happens at the same edge.
- resync=1 (without reset):
  - expected_sum <= accumulator, plus value if valid=1 that cycle.
  - mismatch is not updated that cycle.
  - overflow is left unchanged.
- Compare: every cycle without reset or resync, if accumulator != expected_sum then mismatch<=1 (sticky until reset).
- Since the accumulator has no reset, the environment must pulse resync after reset before any pop for the compare to be meaningful.
- X-safety: no output depends on unwritten FIFO entries.

Test Plan:
1. Reset, resync with accumulator=0, then push 1,2,3 on consecutive cycles with drain_en=1 → valid high for 3 consecutive cycles starting 2 cycles after the first push; value=1,2,3; expected_sum=6; accumulator=6; mismatch=0.
2. drain_en=0, push continuously with DEPTH=8 → 8 accepts; count=8; in_ready=0 from the cycle after the 8th push. Then drain_en=1 with in_valid held → in_ready=1 the cycle after the first pop; output order is preserved with no lost or duplicated entries.
3. Full FIFO, in_valid=1, drain_en=1 in the same cycle → pop only, no push; count 8→7; next cycle push+pop keeps count=7.
4. resync with accumulator=0xFFFF_FFF0, then push 0x20 → expected_sum=0x10; overflow=1; mismatch=0 because the accumulator wraps identically.
5. Force accumulator to an off-by-one value (expected_sum+1) for 1 cycle → mismatch=1 and stays 1 after accumulator is corrected; cleared only by reset.
6. Assert reset for 1 cycle with count=5 and valid=1 → next cycle count=0, valid=0, expected_sum=0, flags=0; a subsequent push/drain yields only the new data.
